// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types and hex 7-segment table for the digit scan controller
package seg_pkg;

    typedef enum logic {BLANK, DRIVE} phase_e;

    typedef struct packed {
        logic [3:0] value;
        logic       dp;
        logic       on;
    } digit_rec_t;

    // Segment order within each entry is {g,f,e,d,c,b,a}
    localparam logic [0:15][6:0] SEG7_HEX = {
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [7:0] seg_encode(input digit_rec_t rec);
        return {rec.dp, SEG7_HEX[rec.value]};
    endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running digit-slot counter with slot-start flag
module tick_gen #(
    parameter int S  = 8,
    parameter int CW = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    output logic          slot_start,
    output logic [CW-1:0] cnt
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (cnt == CW'(S - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign slot_start = (cnt == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed 7-segment scan controller with slot-aligned digit writes
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int   CLK_IN_MHZ     = 125,
    parameter int   NUM_DIGITS     = 3,
    parameter int   SCAN_HZ        = 1000,
    parameter int   DWELL_OVERRIDE = 0,
    parameter int   BLANK_CYCLES   = 2,
    parameter logic LED_POLARITY   = 1'b0,
    parameter logic SEL_ACTIVE     = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    input  logic [1:0]            wr_digit_i,
    input  logic [3:0]            wr_value_i,
    input  logic                  wr_dp_i,
    input  logic                  wr_on_i,
    output logic                  wr_err_o,
    output logic [7:0]            display_o,
    output logic [NUM_DIGITS-1:0] seg_sel_o,
    output logic                  frame_o
);

    localparam int S  = (DWELL_OVERRIDE != 0) ? DWELL_OVERRIDE : (CLK_IN_MHZ * 1000000) / SCAN_HZ;
    localparam int CW = (S > 1) ? $clog2(S) : 1;
    localparam logic [7:0]            SEG_OFF = LED_POLARITY ? 8'h00 : 8'hFF;
    localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{~SEL_ACTIVE}};
    localparam logic [2:0]            NUM_D3  = 3'(NUM_DIGITS);

    logic          slot_start;
    logic [CW-1:0] cnt;
    logic [1:0]    dig;
    logic          pending;
    logic [1:0]    pend_dig;
    digit_rec_t    pend_rec;
    digit_rec_t    store [0:3];
    logic          err_q;
    logic [7:0]    disp_q, disp_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d, onehot;
    logic          frame_q;
    phase_e        phase;
    digit_rec_t    cur;
    logic          wr_fire, wr_in_range;

    tick_gen #(.S(S), .CW(CW)) u_tick (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .slot_start (slot_start),
        .cnt        (cnt)
    );

    assign wr_fire     = wr_valid_i && !pending;
    assign wr_in_range = ({1'b0, wr_digit_i} < NUM_D3);

    // Pending writes land only at slot boundaries so a lit digit never changes mid-dwell
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dig      <= '0;
            pending  <= 1'b0;
            pend_dig <= '0;
            pend_rec <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < 4; i++) store[i] <= '0;
        end else begin
            err_q <= wr_fire && !wr_in_range;
            if (cnt == CW'(S - 1)) begin
                dig <= (dig == 2'(NUM_DIGITS - 1)) ? 2'd0 : dig + 2'd1;
            end
            if (slot_start && pending) begin
                store[pend_dig] <= pend_rec;
                pending         <= 1'b0;
            end else if (wr_fire && wr_in_range) begin
                pending  <= 1'b1;
                pend_dig <= wr_digit_i;
                pend_rec <= '{value: wr_value_i, dp: wr_dp_i, on: wr_on_i};
            end
        end
    end

    always_comb begin
        phase  = (cnt < CW'(BLANK_CYCLES)) ? BLANK : DRIVE;
        cur    = store[dig];
        onehot = NUM_DIGITS'(1) << dig;
        disp_d = SEG_OFF;
        sel_d  = SEL_OFF;
        if (phase == DRIVE && cur.on) begin
            disp_d = LED_POLARITY ? seg_encode(cur) : ~seg_encode(cur);
            sel_d  = SEL_ACTIVE ? onehot : ~onehot;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            disp_q  <= SEG_OFF;
            sel_q   <= SEL_OFF;
            frame_q <= 1'b0;
        end else begin
            disp_q  <= disp_d;
            sel_q   <= sel_d;
            frame_q <= slot_start && (dig == 2'd0);
        end
    end

    assign wr_ready_o = !pending;
    assign wr_err_o   = err_q;
    assign display_o  = disp_q;
    assign seg_sel_o  = sel_q;
    assign frame_o    = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl against a time-indexed display model
module tb_seg_scan_ctrl;

    localparam int N  = 3;
    localparam int S  = 8;
    localparam int B  = 2;
    localparam int FR = N * S;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       wr_valid_i = 1'b0;
    logic       wr_ready_o;
    logic [1:0] wr_digit_i = '0;
    logic [3:0] wr_value_i = '0;
    logic       wr_dp_i = 1'b0;
    logic       wr_on_i = 1'b0;
    logic       wr_err_o;
    logic [7:0] display_o;
    logic [2:0] seg_sel_o;
    logic       frame_o;

    int errors = 0;
    int checks = 0;
    int t = 0;
    int m_val [N];
    int m_dp  [N];
    int m_on  [N];
    int pq [$];
    logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .CLK_IN_MHZ     (125),
        .NUM_DIGITS     (N),
        .SCAN_HZ        (1000),
        .DWELL_OVERRIDE (S),
        .BLANK_CYCLES   (B),
        .LED_POLARITY   (1'b0),
        .SEL_ACTIVE     (1'b1)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .wr_valid_i (wr_valid_i),
        .wr_ready_o (wr_ready_o),
        .wr_digit_i (wr_digit_i),
        .wr_value_i (wr_value_i),
        .wr_dp_i    (wr_dp_i),
        .wr_on_i    (wr_on_i),
        .wr_err_o   (wr_err_o),
        .display_o  (display_o),
        .seg_sel_o  (seg_sel_o),
        .frame_o    (frame_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    // Position t since reset release: digit = (t/S)%N, offset in slot = t%S
    task automatic cycle();
        int c, d, w;
        logic [7:0] e_disp;
        logic [2:0] e_sel;
        logic e_frame, e_err, e_ready, acc;
        e_ready = (pq.size() == 0);
        chk("ready", 32'(wr_ready_o), 32'(e_ready));
        c = t % S;
        d = (t / S) % N;
        if (c >= B && m_on[d] != 0) begin
            e_disp = ~{m_dp[d][0], hex_tbl[m_val[d]]};
            e_sel  = 3'(1 << d);
        end else begin
            e_disp = 8'hFF;
            e_sel  = 3'b000;
        end
        e_frame = ((t % FR) == 0);
        if (c == 0 && pq.size() > 0) begin
            w = pq.pop_front();
            m_val[(w >> 6) & 3] = (w >> 2) & 15;
            m_dp[(w >> 6) & 3]  = (w >> 1) & 1;
            m_on[(w >> 6) & 3]  = w & 1;
        end
        acc   = wr_valid_i && e_ready;
        e_err = acc && (int'(wr_digit_i) >= N);
        if (acc && int'(wr_digit_i) < N)
            pq.push_back(int'({wr_digit_i, wr_value_i, wr_dp_i, wr_on_i}));
        @(posedge clk);
        #1;
        t++;
        chk("display", 32'(display_o), 32'(e_disp));
        chk("seg_sel", 32'(seg_sel_o), 32'(e_sel));
        chk("frame",   32'(frame_o),   32'(e_frame));
        chk("wr_err",  32'(wr_err_o),  32'(e_err));
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst_i      = 1'b1;
        wr_valid_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk("rst_display", 32'(display_o), 32'hFF);
            chk("rst_sel",     32'(seg_sel_o), 32'h0);
            chk("rst_frame",   32'(frame_o),   32'h0);
            chk("rst_err",     32'(wr_err_o),  32'h0);
            chk("rst_ready",   32'(wr_ready_o), 32'h1);
            @(negedge clk);
        end
        rst_i = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_val[i] = 0;
            m_dp[i]  = 0;
            m_on[i]  = 0;
        end
        pq.delete();
        t = 0;
    endtask

    task automatic wr(input int dg, input int v, input int dp, input int on);
        logic was_ready;
        logic accepted = 1'b0;
        wr_valid_i = 1'b1;
        wr_digit_i = 2'(dg);
        wr_value_i = 4'(v);
        wr_dp_i    = dp[0];
        wr_on_i    = on[0];
        for (int k = 0; k < 2 * S + 2; k++) begin
            was_ready = wr_ready_o;
            cycle();
            if (was_ready) begin
                accepted = 1'b1;
                break;
            end
        end
        wr_valid_i = 1'b0;
        chk("wr_accept", 32'(accepted), 32'h1);
    endtask

    task automatic run_until(input int p);
        for (int k = 0; k < FR && (t % FR) != p; k++) cycle();
    endtask

    initial begin
        @(negedge clk);
        do_reset(3);
        repeat (30) cycle();

        wr(0, 5, 0, 1);
        repeat (FR) cycle();
        run_until(1);
        cycle();
        chk("d0_blank_disp", 32'(display_o), 32'hFF);
        run_until(3);
        cycle();
        chk("d0_five_disp", 32'(display_o), 32'h92);
        chk("d0_five_sel",  32'(seg_sel_o), 32'h1);

        wr(1, 10, 1, 1);
        wr(2, 3, 0, 1);
        repeat (FR) cycle();
        run_until(11);
        cycle();
        chk("d1_a_disp", 32'(display_o), 32'h08);
        chk("d1_a_sel",  32'(seg_sel_o), 32'h2);
        run_until(19);
        cycle();
        chk("d2_three_disp", 32'(display_o), 32'hB0);
        chk("d2_three_sel",  32'(seg_sel_o), 32'h4);

        wr_valid_i = 1'b1;
        wr_digit_i = 2'd3;
        wr_value_i = 4'hE;
        wr_on_i    = 1'b1;
        cycle();
        wr_valid_i = 1'b0;
        chk("oor_err_pulse", 32'(wr_err_o),   32'h1);
        chk("oor_ready",     32'(wr_ready_o), 32'h1);
        cycle();
        chk("oor_err_clear", 32'(wr_err_o), 32'h0);
        repeat (FR) cycle();

        run_until(4);
        wr(0, 7, 0, 1);
        cycle();
        chk("live_old_disp", 32'(display_o), 32'h92);
        run_until(3);
        cycle();
        chk("live_new_disp", 32'(display_o), 32'hF8);

        wr(0, 0, 0, 0);
        repeat (FR) cycle();
        run_until(4);
        cycle();
        chk("off_sel",  32'(seg_sel_o), 32'h0);
        chk("off_disp", 32'(display_o), 32'hFF);
        run_until(13);
        do_reset(2);
        repeat (2 * FR) cycle();
        run_until(12);
        cycle();
        chk("post_rst_dark", 32'(seg_sel_o), 32'h0);

        repeat (600) begin
            wr_valid_i = ($urandom_range(0, 3) == 0);
            wr_digit_i = 2'($urandom);
            wr_value_i = 4'($urandom);
            wr_dp_i    = 1'($urandom);
            wr_on_i    = ($urandom_range(0, 3) != 0);
            cycle();
        end
        wr_valid_i = 1'b0;
        repeat (FR) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
